// File: rtl/pkt_write_ctl.sv
// Packet ingress write controller.
// Asks the SRAM allocator for a contiguous region for each packet, writes the packet beats into
// it at consecutive word addresses, then hands a descriptor (start, written length, error) on.
// Packets that cannot be placed (no space, or zero declared length) are drained and counted.
module pkt_write_ctl #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    // packet stream
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_in_sop,
    input  logic              i_in_eop,
    input  logic [LEN_W-1:0]  i_in_len,
    input  logic [DATA_W-1:0] i_in_data,
    // allocator
    output logic              o_alloc_req,
    output logic [LEN_W-1:0]  o_alloc_size,
    input  logic              i_alloc_gnt,
    input  logic [ADDR_W-1:0] i_alloc_addr,
    input  logic              i_alloc_fail,
    // SRAM write port
    output logic              o_sram_we,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    // descriptor
    output logic              o_desc_valid,
    output logic [ADDR_W-1:0] o_desc_addr,
    output logic [LEN_W-1:0]  o_desc_len,
    output logic              o_desc_err,
    input  logic              i_desc_ready,
    // statistics
    output logic [CNT_W-1:0]  o_drop_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StAlloc,
        StWrite,
        StDrain,
        StDesc
    } state_t;

    state_t              r_state;
    logic [LEN_W-1:0]    r_len;
    logic [ADDR_W-1:0]   r_base;
    // One extra bit so over-long packets can be counted past len without wrapping.
    logic [LEN_W:0]      r_idx;
    logic                r_err;
    logic                r_in_ready;
    logic                r_alloc_req;
    logic                r_sram_we;
    logic [ADDR_W-1:0]   r_sram_addr;
    logic [DATA_W-1:0]   r_sram_wdata;
    logic                r_desc_valid;
    logic [ADDR_W-1:0]   r_desc_addr;
    logic [LEN_W-1:0]    r_desc_len;
    logic                r_desc_err;
    logic [CNT_W-1:0]    r_drop_cnt;

    logic                w_accept;
    logic [LEN_W:0]      w_idx_inc;
    logic [LEN_W:0]      w_len_ext;
    logic                w_in_range;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic                w_beat_err;
    logic                w_len_mismatch;
    logic [LEN_W-1:0]    w_desc_len;
    logic [CNT_W-1:0]    w_drop_inc;

    // Beat bookkeeping derived from the current index, length and incoming beat.
    always_comb begin
        w_accept       = i_in_valid & r_in_ready;
        w_idx_inc      = (&r_idx) ? r_idx : r_idx + {{LEN_W{1'b0}}, 1'b1};
        w_len_ext      = {1'b0, r_len};
        w_in_range     = r_idx < w_len_ext;
        // Address arithmetic wraps modulo the SRAM size.
        w_wr_addr      = r_base + ADDR_W'(r_idx);
        // A beat past len, or a second sop inside the packet, marks the packet bad.
        w_beat_err     = !w_in_range || (i_in_sop && (r_idx != '0));
        w_len_mismatch = w_idx_inc != w_len_ext;
        // Written words are min(beats received, len).
        w_desc_len     = (w_idx_inc > w_len_ext) ? r_len : w_idx_inc[LEN_W-1:0];
        w_drop_inc     = (&r_drop_cnt) ? r_drop_cnt : r_drop_cnt + CNT_W'(1);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_len        <= '0;
            r_base       <= '0;
            r_idx        <= '0;
            r_err        <= 1'b0;
            r_in_ready   <= 1'b0;
            r_alloc_req  <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_desc_valid <= 1'b0;
            r_desc_addr  <= '0;
            r_desc_len   <= '0;
            r_desc_err   <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_sram_we <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid && i_in_sop && !r_in_ready) begin
                        // The sop beat stays on the bus; WRITE or DRAIN consumes it.
                        r_in_ready <= (i_in_len == '0);
                        if (i_in_len != '0) begin
                            r_len       <= i_in_len;
                            r_alloc_req <= 1'b1;
                            r_state     <= StAlloc;
                        end else begin
                            r_drop_cnt <= w_drop_inc;
                            r_state    <= StDrain;
                        end
                    end else begin
                        // Orphan beats are swallowed one at a time: ready rises a cycle
                        // after the orphan is seen and drops once it has been taken.
                        r_in_ready <= i_in_valid && !i_in_sop && !r_in_ready;
                    end
                end
                StAlloc: begin
                    if (i_alloc_gnt) begin
                        r_base      <= i_alloc_addr;
                        r_idx       <= '0;
                        r_err       <= 1'b0;
                        r_alloc_req <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StWrite;
                    end else if (i_alloc_fail) begin
                        r_drop_cnt  <= w_drop_inc;
                        r_alloc_req <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StDrain;
                    end
                end
                StWrite: begin
                    if (w_accept) begin
                        if (w_in_range) begin
                            r_sram_we    <= 1'b1;
                            r_sram_addr  <= w_wr_addr;
                            r_sram_wdata <= i_in_data;
                        end
                        r_idx <= w_idx_inc;
                        if (i_in_eop) begin
                            r_in_ready   <= 1'b0;
                            r_desc_valid <= 1'b1;
                            r_desc_addr  <= r_base;
                            r_desc_len   <= w_desc_len;
                            r_desc_err   <= r_err | w_beat_err | w_len_mismatch;
                            r_state      <= StDesc;
                        end else begin
                            r_err <= r_err | w_beat_err;
                        end
                    end
                end
                StDrain: begin
                    if (w_accept && i_in_eop) begin
                        r_in_ready <= 1'b0;
                        r_state    <= StIdle;
                    end
                end
                StDesc: begin
                    if (i_desc_ready) begin
                        r_desc_valid <= 1'b0;
                        r_state      <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_alloc_req  = r_alloc_req;
    assign o_alloc_size = r_len;
    assign o_sram_we    = r_sram_we;
    assign o_sram_addr  = r_sram_addr;
    assign o_sram_wdata = r_sram_wdata;
    assign o_desc_valid = r_desc_valid;
    assign o_desc_addr  = r_desc_addr;
    assign o_desc_len   = r_desc_len;
    assign o_desc_err   = r_desc_err;
    assign o_drop_cnt   = r_drop_cnt;

endmodule
